// File: rtl/uart_echo_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_checker_if
// Purpose  : Byte-level link between the echo checker and the UART
//            transmitter/receiver pair it drives and listens to.
// Signals  : tx_byte_out       [7:0] byte offered to the transmitter
//            tx_byte_valid_out       transmit request
//            tx_byte_done            transmitter idle/ready
//            rx_byte           [7:0] byte held by the receiver
//            rx_byte_valid           receiver holds a byte
//            rx_byte_done_out        one-cycle pop pulse to the receiver
// Modports : master - the checker; slave - the UART side
// Revision : 1.0 - initial release
// ============================================================================
interface uart_echo_checker_if;
  logic [7:0] tx_byte_out;
  logic       tx_byte_valid_out;
  logic       tx_byte_done;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       rx_byte_done_out;

  modport master (
    output tx_byte_out,
    output tx_byte_valid_out,
    output rx_byte_done_out,
    input  tx_byte_done,
    input  rx_byte,
    input  rx_byte_valid
  );

  modport slave (
    input  tx_byte_out,
    input  tx_byte_valid_out,
    input  rx_byte_done_out,
    output tx_byte_done,
    output rx_byte,
    output rx_byte_valid
  );
endinterface
`default_nettype wire

// File: rtl/uart_echo_checker.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_checker
// Purpose  : Stop-and-wait UART echo self-test initiator. Sends an LFSR byte
//            sequence through the transmitter, waits for each echo from the
//            receiver, counts mismatches and stray bytes, and reports
//            pass / timeout at the end of each run.
// Ports    : clk, rst_n (async, active-low)
//            start            pulse, begins a run when idle
//            seed       [7:0] LFSR seed (zero is replaced by 8'h01)
//            link             uart_echo_checker_if.master (tx/rx byte links)
//            busy_out         run in progress
//            done_out         one-cycle end-of-run pulse
//            pass_out         last run clean; holds until next start
//            timeout_out      last run aborted waiting for an echo
//            error_count_out  mismatches + stray bytes, saturating
// Revision : 1.0 - initial release
// ============================================================================
module uart_echo_checker #(
  parameter int ByteCount     = 4,
  parameter int TimeoutCycles = 65535
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start,
  input  wire logic [7:0]        seed,
  uart_echo_checker_if.master    link,
  output      logic              busy_out,
  output      logic              done_out,
  output      logic              pass_out,
  output      logic              timeout_out,
  output      logic [7:0]        error_count_out
);

  localparam logic [7:0]  LAST_INDEX   = 8'(ByteCount - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND   = 3'd1,
    WAIT   = 3'd2,
    CHECK  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  lfsr;
  logic [7:0]  index;
  logic [7:0]  error_count;
  logic [7:0]  error_next;
  logic [15:0] wait_count;
  logic        pass;
  logic        timeout;
  logic        error_hit;
  logic [7:0]  lfsr_next;

  // The byte on the wire is the LFSR itself: it only advances in CHECK,
  // so it is stable for the whole time the request is raised.
  assign link.tx_byte_out = lfsr;
  assign lfsr_next        = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // A byte arriving while we are still sending is a stray; in CHECK a
  // mismatch against the byte just sent counts. Both saturate at 8'hff.
  assign error_hit  = ((state == SEND) && link.rx_byte_valid) ||
                      ((state == CHECK) && (link.rx_byte != lfsr));
  assign error_next = (error_hit && (error_count != 8'hff)) ? error_count + 8'd1
                                                           : error_count;

  assign pass_out        = pass;
  assign timeout_out     = timeout;
  assign error_count_out = error_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next             = state;
    link.tx_byte_valid_out = 1'b0;
    link.rx_byte_done_out  = 1'b0;
    busy_out               = 1'b0;
    done_out               = 1'b0;
    case (state)
      IDLE: begin
        // Anything the receiver holds while idle is discarded silently.
        link.rx_byte_done_out = link.rx_byte_valid;
        if (start) state_next = SEND;
      end
      SEND: begin
        busy_out               = 1'b1;
        link.tx_byte_valid_out = 1'b1;
        link.rx_byte_done_out  = link.rx_byte_valid;
        if (link.tx_byte_done) state_next = WAIT;
      end
      WAIT: begin
        busy_out = 1'b1;
        if (link.rx_byte_valid)             state_next = CHECK;
        else if (wait_count == TIMEOUT_LAST) state_next = FINISH;
      end
      CHECK: begin
        busy_out              = 1'b1;
        link.rx_byte_done_out = link.rx_byte_valid;
        state_next            = (index == LAST_INDEX) ? FINISH : SEND;
      end
      FINISH: begin
        done_out   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr        <= 8'hff;
      index       <= 8'd0;
      error_count <= 8'd0;
      wait_count  <= 16'd0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lfsr        <= (seed == 8'h00) ? 8'h01 : seed;
            index       <= 8'd0;
            error_count <= 8'd0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        SEND: begin
          // Counter is zero on the first WAIT cycle.
          wait_count  <= 16'd0;
          error_count <= error_next;
        end
        WAIT: begin
          if (!link.rx_byte_valid) begin
            if (wait_count == TIMEOUT_LAST) begin
              timeout <= 1'b1;
              pass    <= 1'b0;
            end else begin
              wait_count <= wait_count + 16'd1;
            end
          end
        end
        CHECK: begin
          error_count <= error_next;
          lfsr        <= lfsr_next;
          index       <= index + 8'd1;
          // Settled here so pass_out is already valid during the done pulse.
          if (index == LAST_INDEX) pass <= (error_next == 8'd0);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_echo_checker
// Purpose  : Self-checking bench for uart_echo_checker. Plays the role of the
//            transmitter/receiver pair, echoing (optionally corrupting) each
//            byte, and compares every observable against a queue-based model
//            of the expected byte sequence and run result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_echo_checker;
  localparam int NB   = 4;
  localparam int TOUT = 100;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] seed;
  logic       busy;
  logic       done;
  logic       pass;
  logic       timeout;
  logic [7:0] err_count;
  int         checks;
  int         errors;

  uart_echo_checker_if link ();

  uart_echo_checker #(.ByteCount(NB), .TimeoutCycles(TOUT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .seed            (seed),
    .link            (link),
    .busy_out        (busy),
    .done_out        (done),
    .pass_out        (pass),
    .timeout_out     (timeout),
    .error_count_out (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feedback is the parity of taps 7,5,4,3.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & 8'b1011_1000)};
  endfunction

  // One echoed run: corrupt = index of byte to flip (-1 none), stray = inject
  // a receiver byte while byte 1 is being offered, hold = cycles to stall the
  // transmitter on byte 0, mid_start = pulse start during the first wait.
  task automatic run(input logic [7:0] sd, input int corrupt, input bit stray,
                     input int hold, input bit mid_start);
    logic [7:0] exp_q[$];
    logic [7:0] l;
    logic [7:0] held;
    int         exp_err;
    int         guard;
    bit         stable;
    l = (sd == 8'h00) ? 8'h01 : sd;
    exp_q = {};
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back(l);
      l = lfsr_step(l);
    end
    exp_err = ((corrupt >= 0) ? 1 : 0) + (stray ? 1 : 0);

    seed = sd; start = 1'b1; tick(); start = 1'b0; seed = 8'($urandom);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < NB; i++) begin
      guard = 0;
      while (!link.tx_byte_valid_out && guard < 50) begin tick(); guard++; end
      chk("tx_valid", link.tx_byte_valid_out, 1);
      chk("tx_byte", link.tx_byte_out, exp_q[i]);
      if (stray && i == 1) begin
        link.tx_byte_done = 1'b0;
        link.rx_byte = 8'($urandom);
        link.rx_byte_valid = 1'b1;
        #1 chk("stray_pop", link.rx_byte_done_out, 1);
        @(posedge clk); #1;
        link.rx_byte_valid = 1'b0;
        link.tx_byte_done = 1'b1;
        tick();
      end
      if (hold > 0 && i == 0) begin
        link.tx_byte_done = 1'b0;
        held = link.tx_byte_out;
        stable = 1'b1;
        repeat (hold) begin
          tick();
          stable &= link.tx_byte_valid_out && (link.tx_byte_out == held);
        end
        chk("hold_stable", stable, 1);
        link.tx_byte_done = 1'b1;
      end
      tick();
      chk("tx_valid_drop", link.tx_byte_valid_out, 0);
      if (mid_start && i == 0) begin
        seed = 8'($urandom); start = 1'b1; tick(); start = 1'b0;
      end
      repeat ($urandom_range(0, 4)) tick();
      chk("no_pop_in_wait", link.rx_byte_done_out, 0);
      link.rx_byte = exp_q[i] ^ ((i == corrupt) ? 8'h10 : 8'h00);
      link.rx_byte_valid = 1'b1;
      guard = 0;
      tick();
      while (!link.rx_byte_done_out && guard < 10) begin tick(); guard++; end
      chk("echo_pop", link.rx_byte_done_out, 1);
      @(posedge clk); #1;
      link.rx_byte_valid = 1'b0;
      tick();
      chk("single_pop", link.rx_byte_done_out, 0);
    end
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    chk("pass", pass, (exp_err == 0) ? 1 : 0);
    chk("error_count", err_count, exp_err);
    chk("timeout_clear", timeout, 0);
    tick();
    chk("done_one_cycle", done, 0);
    chk("pass_holds", pass, (exp_err == 0) ? 1 : 0);
  endtask

  task automatic run_timeout(input logic [7:0] sd);
    int n;
    seed = sd; start = 1'b1; tick(); start = 1'b0;
    chk("to_tx_valid", link.tx_byte_valid_out, 1);
    chk("to_tx_byte", link.tx_byte_out, (sd == 8'h00) ? 8'h01 : sd);
    tick();
    chk("to_valid_drop", link.tx_byte_valid_out, 0);
    n = 0;
    while (!done && n < TOUT + 20) begin tick(); n++; end
    chk("timeout_latency", n, TOUT);
    chk("timeout_flag", timeout, 1);
    chk("timeout_pass", pass, 0);
    chk("timeout_busy", busy, 0);
    chk("timeout_errs", err_count, 0);
    tick();
    chk("timeout_done_one_cycle", done, 0);
    chk("timeout_holds", timeout, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; seed = 8'h00;
    link.tx_byte_done = 1'b1; link.rx_byte = 8'h00; link.rx_byte_valid = 1'b0;
    repeat (3) tick();
    chk("reset_outputs",
        {link.tx_byte_out, link.tx_byte_valid_out, link.rx_byte_done_out,
         busy, done, pass, timeout, err_count},
        {8'hff, 6'b0, 8'h00});
    rst_n = 1'b1;
    tick();

    run(8'h01, -1, 1'b0, 0, 1'b0);            // clean loopback 01,02,04,08
    run(8'h01,  2, 1'b0, 0, 1'b0);            // one corrupted echo
    run_timeout(8'($urandom));                // no echo
    run(8'h00, -1, 1'b0, 0, 1'b1);            // zero seed, ignored mid-run start

    // Asynchronous reset while waiting for the echo.
    seed = 8'h5a; start = 1'b1; tick(); start = 1'b0;
    tick();
    #3 rst_n = 1'b0;
    #1 chk("async_reset_outputs",
           {link.tx_byte_out, link.tx_byte_valid_out, link.rx_byte_done_out,
            busy, done, pass, timeout, err_count},
           {8'hff, 6'b0, 8'h00});
    tick(); rst_n = 1'b1; tick();
    run(8'($urandom), -1, 1'b0, 0, 1'b0);

    run(8'($urandom), -1, 1'b0, 50, 1'b0);    // transmitter stalled 50 clks

    // Byte sitting in the receiver while idle: popped, not counted.
    link.rx_byte = 8'($urandom); link.rx_byte_valid = 1'b1;
    #1 chk("idle_pop", link.rx_byte_done_out, 1);
    @(posedge clk); #1 link.rx_byte_valid = 1'b0;
    tick();
    run(8'($urandom), -1, 1'b0, 0, 1'b0);

    run(8'($urandom), -1, 1'b1, 0, 1'b0);     // stray byte during send

    for (int r = 0; r < 4; r++) begin
      run(8'($urandom), int'($urandom_range(0, 4)) - 1,
          1'($urandom_range(0, 1)), 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
